axi_lite_ctrl_slave: RTL and testbench
======================================

// Module: axi_lite_ctrl_slave
// PURPOSE
//  AXI4-Lite slave: the endpoint that sits downstream of the axi_lite_if bus and consumes its
//  five channels. Decodes a 4-word control/status register bank for the RV32IM_Zbb core.
//  Exposes core controls: start pulse, core reset, boot address. Captures core busy/done status.
// PARAMETERS
//  AXI_DATA_WIDTH  32  data bus width; only 32 is supported (elaboration error otherwise)
//  AXI_ADDR_WIDTH  4   byte address width; ADDR[3:2] selects the word, ADDR[1:0] and upper bits ignored
//  BOOT_RESET      32'h0000_0000  reset value of BOOT_ADDR register
// PORTS
//  clk          in   1   clock, all logic rising-edge
//  reset        in   1   asynchronous, active-high reset
//  AWADDR/AWPROT/AWVALID in  A/3/1  write address; AWPROT ignored
//  AWREADY      out  1   write address accept
//  WDATA/WSTRB/WVALID    in  32/4/1  write data, byte strobes
//  WREADY       out  1   write data accept
//  BRESP/BVALID out  2/1 write response
//  BREADY       in   1   master accepts response
//  ARADDR/ARPROT/ARVALID in  A/3/1  read address; ARPROT ignored
//  ARREADY      out  1   read address accept
//  RDATA/RRESP/RVALID    out 32/2/1  read data, response
//  RREADY       in   1   master accepts read data
//  start_o      out  1   one-cycle core start pulse
//  core_rst_o   out  1   level core reset request (CTRL[1])
//  boot_addr_o  out  32  core boot PC (BOOT_ADDR register)
//  busy_i       in   1   core running
//  done_i       in   1   core finished (pulse or level)
// BEHAVIOUR
//  Register map, by word index: 0 CTRL [0]=start (W, reads 0), [1]=core_rst (RW). 1 STATUS [0]=busy (RO), [1]=done (sticky, W1C).
//   2 BOOT_ADDR (RW). 3 SCRATCH (RW). Unused bits read 0.
//  Reset: all outputs 0. Registers: CTRL=0, done=0, BOOT_ADDR=BOOT_RESET, SCRATCH=0.
//   Any in-flight transaction is dropped; no B/R response is issued for it.
//  Write path: AW and W are accepted independently, in any order or in the same cycle. Each has a one-entry holding latch.
//   AWREADY=!aw_held && !BVALID. WREADY=!w_held && !BVALID. Both READYs are registered and rise the cycle after reset deasserts.
//   Once both are held, the write commits on the next edge with WSTRB byte-masking. At that edge BVALID=1, BRESP=00, and the latches clear.
//   BVALID and BRESP are held stable until BREADY. New AW/W are accepted only after the B handshake.
//   Write to STATUS: bit1=1 clears done; other bits are ignored; BRESP=00.
//   Write CTRL[0]=1: start_o=1 for exactly the cycle after commit. It is not stored.
//  Read path: ARREADY=!RVALID. AR handshake -> the next edge latches RDATA with RVALID=1 and RRESP=00 (1-cycle latency).
//   RDATA/RVALID are held until RREADY. ARREADY returns high the cycle after the R handshake, giving 1 read per 2 cycles.
//  done capture: done_i high sets done on the next edge. Set wins over a simultaneous W1C.
//  Simultaneous read and write to the same word: the read samples the pre-commit value.
//  BOOT_ADDR and core_rst are writable while busy_i=1; there is no interlock.
//  Single FSM per channel. Write: W_IDLE (collecting AW/W) -> W_RESP (BVALID) -> W_IDLE on BREADY.
//   Read: R_IDLE -> R_DATA -> R_IDLE on RREADY.
// STRUCTURE
//  Shared package axi_lite_pkg: resp_t enum (OKAY=2'b00, SLVERR=2'b10), register index localparams,
//   CTRL/STATUS bit-position constants.
//  Sub-module: axi_lite_ctrl_regs (register bank, strobe merge, W1C/sticky logic).
//   Channel handshakes and FSMs stay in the top.
// TESTING
//  AW at t0, W at t3 (VALIDs held) -> AWREADY drops t1, commit t4, BVALID t4 with BRESP=00.
//   Readback of SCRATCH returns the written data.
//  W before AW, same write 0xDEADBEEF to BOOT_ADDR with WSTRB=4'b0011 -> boot_addr_o=0x0000BEEF (from reset 0).
//  Write CTRL=0x1 -> start_o high exactly 1 cycle. Read CTRL -> 0x0. Write CTRL=0x2 -> core_rst_o=1.
//  done_i pulse, then read STATUS -> 0x2. Write STATUS=0x2 with done_i high same cycle -> done stays 1.
//  BREADY/RREADY held low 5 cycles -> BVALID/RVALID and data stable. No further AWREADY/ARREADY during the hold.
//  Assert reset while BVALID=1 -> all outputs 0 immediately. Next transaction after release completes normally.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite control slave: response codes, register map,
// bit positions and the per-channel FSM state types.
package axi_lite_pkg;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      SLVERR = 2'b10
   } resp_t;

   typedef enum logic {
      W_IDLE,
      W_RESP
   } wstate_t;

   typedef enum logic {
      R_IDLE,
      R_DATA
   } rstate_t;

   localparam logic [1:0] REG_CTRL    = 2'd0;
   localparam logic [1:0] REG_STATUS  = 2'd1;
   localparam logic [1:0] REG_BOOT    = 2'd2;
   localparam logic [1:0] REG_SCRATCH = 2'd3;

   localparam int CTRL_START_BIT    = 0;
   localparam int CTRL_CORE_RST_BIT = 1;
   localparam int STATUS_BUSY_BIT   = 0;
   localparam int STATUS_DONE_BIT   = 1;

   function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
      logic [31:0] merged;
      merged = old_val;
      for (int i = 0; i < 4; i++) begin
         if (strb[i]) merged[i*8 +: 8] = new_val[i*8 +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/axi_lite_ctrl_regs.sv
// Control/status register bank: byte-strobe merge on commit, start pulse generation,
// sticky done flag with write-one-to-clear, and the combinational read mux.
module axi_lite_ctrl_regs
   import axi_lite_pkg::*;
#(
   parameter logic [31:0] BOOT_RESET = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wr_en,
   input  logic [1:0]  wr_idx,
   input  logic [31:0] wr_data,
   input  logic [3:0]  wr_strb,
   input  logic [1:0]  rd_idx,
   output logic [31:0] rd_data,
   input  logic        busy_i,
   input  logic        done_i,
   output logic        start_o,
   output logic        core_rst_o,
   output logic [31:0] boot_addr_o
);

   logic        start_q;
   logic        core_rst_q;
   logic        done_q;
   logic [31:0] boot_q;
   logic [31:0] scratch_q;

   logic wr_ctrl;
   logic wr_status;
   logic wr_boot;
   logic wr_scratch;

   assign wr_ctrl    = wr_en && (wr_idx == REG_CTRL);
   assign wr_status  = wr_en && (wr_idx == REG_STATUS);
   assign wr_boot    = wr_en && (wr_idx == REG_BOOT);
   assign wr_scratch = wr_en && (wr_idx == REG_SCRATCH);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         start_q    <= 1'b0;
         core_rst_q <= 1'b0;
         done_q     <= 1'b0;
         boot_q     <= BOOT_RESET;
         scratch_q  <= 32'h0;
      end else begin
         // start is a pulse only; it is never stored as register state
         start_q <= wr_ctrl && wr_strb[0] && wr_data[CTRL_START_BIT];
         if (wr_ctrl && wr_strb[0]) core_rst_q <= wr_data[CTRL_CORE_RST_BIT];
         if (wr_boot)    boot_q    <= strb_merge(boot_q, wr_data, wr_strb);
         if (wr_scratch) scratch_q <= strb_merge(scratch_q, wr_data, wr_strb);
         // a new done event beats a simultaneous clear so no completion is lost
         if (done_i)
            done_q <= 1'b1;
         else if (wr_status && wr_strb[0] && wr_data[STATUS_DONE_BIT])
            done_q <= 1'b0;
      end
   end

   always_comb begin
      rd_data = 32'h0;
      case (rd_idx)
         REG_CTRL:    rd_data[CTRL_CORE_RST_BIT] = core_rst_q;
         REG_STATUS: begin
            rd_data[STATUS_BUSY_BIT] = busy_i;
            rd_data[STATUS_DONE_BIT] = done_q;
         end
         REG_BOOT:    rd_data = boot_q;
         REG_SCRATCH: rd_data = scratch_q;
         default:     rd_data = 32'h0;
      endcase
   end

   assign start_o     = start_q;
   assign core_rst_o  = core_rst_q;
   assign boot_addr_o = boot_q;

endmodule

// File: rtl/axi_lite_ctrl_slave.sv
// AXI4-Lite slave front end for the core control registers: independent AW/W holding
// latches, write and read channel FSMs, registered READY outputs.
module axi_lite_ctrl_slave
   import axi_lite_pkg::*;
#(
   parameter int          AXI_DATA_WIDTH = 32,
   parameter int          AXI_ADDR_WIDTH = 4,
   parameter logic [31:0] BOOT_RESET     = 32'h0000_0000
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [AXI_ADDR_WIDTH-1:0]     AWADDR,
   input  logic [2:0]                    AWPROT,
   input  logic                          AWVALID,
   output logic                          AWREADY,
   input  logic [AXI_DATA_WIDTH-1:0]     WDATA,
   input  logic [AXI_DATA_WIDTH/8-1:0]   WSTRB,
   input  logic                          WVALID,
   output logic                          WREADY,
   output logic [1:0]                    BRESP,
   output logic                          BVALID,
   input  logic                          BREADY,
   input  logic [AXI_ADDR_WIDTH-1:0]     ARADDR,
   input  logic [2:0]                    ARPROT,
   input  logic                          ARVALID,
   output logic                          ARREADY,
   output logic [AXI_DATA_WIDTH-1:0]     RDATA,
   output logic [1:0]                    RRESP,
   output logic                          RVALID,
   input  logic                          RREADY,
   output logic                          start_o,
   output logic                          core_rst_o,
   output logic [31:0]                   boot_addr_o,
   input  logic                          busy_i,
   input  logic                          done_i
);

   if (AXI_DATA_WIDTH != 32) begin : g_bad_data_width
      $error("axi_lite_ctrl_slave: AXI_DATA_WIDTH must be 32");
   end
   if (AXI_ADDR_WIDTH < 4) begin : g_bad_addr_width
      $error("axi_lite_ctrl_slave: AXI_ADDR_WIDTH must be at least 4");
   end

   wstate_t w_state, w_state_n;
   rstate_t r_state, r_state_n;

   logic        aw_held, aw_held_n;
   logic        w_held, w_held_n;
   logic        awready_q, wready_q, arready_q;
   logic [1:0]  aw_idx_q;
   logic [31:0] w_data_q;
   logic [3:0]  w_strb_q;
   logic [31:0] rdata_q;

   logic        aw_hs, w_hs, ar_hs;
   logic        commit;
   logic [1:0]  wr_idx;
   logic [31:0] wr_data;
   logic [3:0]  wr_strb;
   logic [31:0] rd_data;
   logic        unused_bits;

   assign aw_hs = AWVALID && awready_q;
   assign w_hs  = WVALID && wready_q;
   assign ar_hs = ARVALID && arready_q;

   // A beat arriving this cycle is used directly so the commit needs no extra cycle
   assign wr_idx  = aw_held ? aw_idx_q : AWADDR[3:2];
   assign wr_data = w_held  ? w_data_q : WDATA;
   assign wr_strb = w_held  ? w_strb_q : WSTRB;

   always_comb begin
      w_state_n = w_state;
      aw_held_n = aw_held;
      w_held_n  = w_held;
      commit    = 1'b0;
      case (w_state)
         W_IDLE: begin
            aw_held_n = aw_held || aw_hs;
            w_held_n  = w_held || w_hs;
            if (aw_held_n && w_held_n) begin
               commit    = 1'b1;
               aw_held_n = 1'b0;
               w_held_n  = 1'b0;
               w_state_n = W_RESP;
            end
         end
         W_RESP: if (BREADY) w_state_n = W_IDLE;
         default: w_state_n = W_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         w_state   <= W_IDLE;
         aw_held   <= 1'b0;
         w_held    <= 1'b0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
      end else begin
         w_state   <= w_state_n;
         aw_held   <= aw_held_n;
         w_held    <= w_held_n;
         awready_q <= !aw_held_n && (w_state_n == W_IDLE);
         wready_q  <= !w_held_n && (w_state_n == W_IDLE);
      end
   end

   always_ff @(posedge clk) begin
      if (aw_hs) aw_idx_q <= AWADDR[3:2];
      if (w_hs) begin
         w_data_q <= WDATA;
         w_strb_q <= WSTRB;
      end
   end

   always_comb begin
      r_state_n = r_state;
      case (r_state)
         R_IDLE:  if (ar_hs) r_state_n = R_DATA;
         R_DATA:  if (RREADY) r_state_n = R_IDLE;
         default: r_state_n = R_IDLE;
      endcase
   end

   // Read data is captured from the pre-commit register values on the AR edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= R_IDLE;
         arready_q <= 1'b0;
         rdata_q   <= 32'h0;
      end else begin
         r_state   <= r_state_n;
         arready_q <= (r_state_n == R_IDLE);
         if (ar_hs) rdata_q <= rd_data;
      end
   end

   axi_lite_ctrl_regs #(
      .BOOT_RESET(BOOT_RESET)
   ) u_regs (
      .clk        (clk),
      .reset      (reset),
      .wr_en      (commit),
      .wr_idx     (wr_idx),
      .wr_data    (wr_data),
      .wr_strb    (wr_strb),
      .rd_idx     (ARADDR[3:2]),
      .rd_data    (rd_data),
      .busy_i     (busy_i),
      .done_i     (done_i),
      .start_o    (start_o),
      .core_rst_o (core_rst_o),
      .boot_addr_o(boot_addr_o)
   );

   assign AWREADY = awready_q;
   assign WREADY  = wready_q;
   assign ARREADY = arready_q;
   assign BVALID  = (w_state == W_RESP);
   assign BRESP   = OKAY;
   assign RVALID  = (r_state == R_DATA);
   assign RRESP   = OKAY;
   assign RDATA   = rdata_q;

   assign unused_bits = ^{AWADDR, ARADDR, AWPROT, ARPROT};

endmodule

// File: tb/tb_axi_lite_ctrl_slave.sv
// Directed testbench for axi_lite_ctrl_slave: write/read handshakes, strobes, start pulse,
// sticky done, back-pressure holds and reset during an outstanding response.
module tb_axi_lite_ctrl_slave;

   logic        clk;
   logic        reset;
   logic [3:0]  AWADDR;
   logic [2:0]  AWPROT;
   logic        AWVALID;
   logic        AWREADY;
   logic [31:0] WDATA;
   logic [3:0]  WSTRB;
   logic        WVALID;
   logic        WREADY;
   logic [1:0]  BRESP;
   logic        BVALID;
   logic        BREADY;
   logic [3:0]  ARADDR;
   logic [2:0]  ARPROT;
   logic        ARVALID;
   logic        ARREADY;
   logic [31:0] RDATA;
   logic [1:0]  RRESP;
   logic        RVALID;
   logic        RREADY;
   logic        start_o;
   logic        core_rst_o;
   logic [31:0] boot_addr_o;
   logic        busy_i;
   logic        done_i;

   int n_tests;
   int n_fail;

   axi_lite_ctrl_slave dut (
      .clk(clk), .reset(reset),
      .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
      .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
      .start_o(start_o), .core_rst_o(core_rst_o), .boot_addr_o(boot_addr_o),
      .busy_i(busy_i), .done_i(done_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // AW and W presented together; returns start_o as seen in the response cycle
   task automatic do_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic st);
      int n;
      AWADDR = addr; WDATA = data; WSTRB = strb;
      AWVALID = 1'b1; WVALID = 1'b1;
      n = 0;
      @(negedge clk);
      while (!BVALID && n < 20) begin
         @(negedge clk);
         n++;
      end
      AWVALID = 1'b0; WVALID = 1'b0;
      st = start_o;
      check("wr_bvalid", 32'(BVALID), 32'd1);
      BREADY = 1'b1;
      @(negedge clk);
      BREADY = 1'b0;
   endtask

   task automatic do_read(input logic [3:0] addr, output logic [31:0] data);
      int n;
      ARADDR = addr; ARVALID = 1'b1;
      n = 0;
      @(negedge clk);
      while (!RVALID && n < 20) begin
         @(negedge clk);
         n++;
      end
      ARVALID = 1'b0;
      data = RDATA;
      check("rd_rvalid", 32'(RVALID), 32'd1);
      RREADY = 1'b1;
      @(negedge clk);
      RREADY = 1'b0;
   endtask

   initial begin
      logic [31:0] rd;
      logic        st;
      int          n;
      n_tests = 0; n_fail = 0;
      reset = 1'b1;
      AWADDR = '0; AWPROT = '0; AWVALID = 1'b0;
      WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
      ARADDR = '0; ARPROT = '0; ARVALID = 1'b0; RREADY = 1'b0;
      busy_i = 1'b0; done_i = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_awready", 32'(AWREADY), 32'd0);
      check("rst_arready", 32'(ARREADY), 32'd0);
      check("rst_bvalid",  32'(BVALID),  32'd0);
      check("rst_boot",    boot_addr_o,  32'h0);
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_awready", 32'(AWREADY), 32'd1);
      check("post_rst_wready",  32'(WREADY),  32'd1);
      check("post_rst_arready", 32'(ARREADY), 32'd1);

      // AW first, W three cycles later, to SCRATCH
      AWADDR = 4'hC; AWVALID = 1'b1;
      @(negedge clk);
      check("aw_first_awready", 32'(AWREADY), 32'd0);
      check("aw_first_wready",  32'(WREADY),  32'd1);
      @(negedge clk);
      @(negedge clk);
      check("aw_first_nob", 32'(BVALID), 32'd0);
      WDATA = 32'h1234_5678; WSTRB = 4'hF; WVALID = 1'b1;
      @(negedge clk);
      check("aw_first_bvalid", 32'(BVALID), 32'd1);
      check("aw_first_bresp",  32'(BRESP),  32'd0);
      AWVALID = 1'b0; WVALID = 1'b0;
      BREADY = 1'b1;
      @(negedge clk);
      BREADY = 1'b0;
      check("aw_first_b_done", 32'(BVALID), 32'd0);
      do_read(4'hC, rd);
      check("scratch_rb", rd, 32'h1234_5678);

      // W first, partial strobes to BOOT_ADDR
      WDATA = 32'hDEAD_BEEF; WSTRB = 4'b0011; WVALID = 1'b1;
      @(negedge clk);
      check("w_first_wready",  32'(WREADY),  32'd0);
      check("w_first_awready", 32'(AWREADY), 32'd1);
      check("w_first_nob",     32'(BVALID),  32'd0);
      AWADDR = 4'h8; AWVALID = 1'b1;
      @(negedge clk);
      check("w_first_bvalid", 32'(BVALID), 32'd1);
      check("boot_strb", boot_addr_o, 32'h0000_BEEF);
      AWVALID = 1'b0; WVALID = 1'b0;
      BREADY = 1'b1;
      @(negedge clk);
      BREADY = 1'b0;

      // Start pulse, CTRL readback, core reset level
      do_write(4'h0, 32'h1, 4'hF, st);
      check("start_pulse", 32'(st), 32'd1);
      check("start_gone",  32'(start_o), 32'd0);
      do_read(4'h0, rd);
      check("ctrl_rd_start", rd, 32'h0);
      do_write(4'h0, 32'h2, 4'hF, st);
      check("no_start", 32'(st), 32'd0);
      check("core_rst", 32'(core_rst_o), 32'd1);
      do_read(4'h0, rd);
      check("ctrl_rd_rst", rd, 32'h2);

      // Sticky done, busy, W1C racing a new done
      done_i = 1'b1;
      @(negedge clk);
      done_i = 1'b0;
      do_read(4'h4, rd);
      check("status_done", rd, 32'h2);
      busy_i = 1'b1;
      do_read(4'h4, rd);
      check("status_busy_done", rd, 32'h3);
      busy_i = 1'b0;
      done_i = 1'b1;
      do_write(4'h4, 32'h2, 4'hF, st);
      done_i = 1'b0;
      do_read(4'h4, rd);
      check("done_set_wins", rd, 32'h2);
      do_write(4'h4, 32'h2, 4'hF, st);
      do_read(4'h4, rd);
      check("done_w1c", rd, 32'h0);

      // Simultaneous read and write of SCRATCH: read sees old value
      ARADDR = 4'hC; ARVALID = 1'b1;
      AWADDR = 4'hC; AWVALID = 1'b1;
      WDATA = 32'hA5A5_A5A5; WSTRB = 4'hF; WVALID = 1'b1;
      @(negedge clk);
      ARVALID = 1'b0; AWVALID = 1'b0; WVALID = 1'b0;
      check("rw_same_rvalid", 32'(RVALID), 32'd1);
      check("rw_same_old",    RDATA, 32'h1234_5678);
      check("rw_same_bvalid", 32'(BVALID), 32'd1);
      RREADY = 1'b1; BREADY = 1'b1;
      @(negedge clk);
      RREADY = 1'b0; BREADY = 1'b0;
      do_read(4'hC, rd);
      check("rw_same_new", rd, 32'hA5A5_A5A5);

      // Back-pressure on B for 5 cycles
      AWADDR = 4'h8; WDATA = 32'hCAFE_F00D; WSTRB = 4'hF;
      AWVALID = 1'b1; WVALID = 1'b1;
      @(negedge clk);
      AWVALID = 1'b0; WVALID = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("bhold_bvalid",  32'(BVALID),  32'd1);
         check("bhold_awready", 32'(AWREADY), 32'd0);
         @(negedge clk);
      end
      check("bhold_bresp", 32'(BRESP), 32'd0);
      BREADY = 1'b1;
      @(negedge clk);
      BREADY = 1'b0;
      check("bhold_release_awready", 32'(AWREADY), 32'd1);
      check("bhold_boot", boot_addr_o, 32'hCAFE_F00D);

      // Back-pressure on R for 5 cycles
      ARADDR = 4'h8; ARVALID = 1'b1;
      @(negedge clk);
      ARVALID = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("rhold_rvalid",  32'(RVALID),  32'd1);
         check("rhold_rdata",   RDATA,        32'hCAFE_F00D);
         check("rhold_arready", 32'(ARREADY), 32'd0);
         @(negedge clk);
      end
      RREADY = 1'b1;
      @(negedge clk);
      RREADY = 1'b0;
      check("rhold_release_rvalid",  32'(RVALID),  32'd0);
      check("rhold_release_arready", 32'(ARREADY), 32'd1);

      // Reset while a write response is outstanding
      AWADDR = 4'hC; WDATA = 32'h0000_0055; WSTRB = 4'hF;
      AWVALID = 1'b1; WVALID = 1'b1;
      n = 0;
      @(negedge clk);
      while (!BVALID && n < 20) begin
         @(negedge clk);
         n++;
      end
      AWVALID = 1'b0; WVALID = 1'b0;
      check("pre_rst_bvalid", 32'(BVALID), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("mid_rst_bvalid",  32'(BVALID),      32'd0);
      check("mid_rst_awready", 32'(AWREADY),     32'd0);
      check("mid_rst_core",    32'(core_rst_o),  32'd0);
      check("mid_rst_boot",    boot_addr_o,      32'h0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("after_rst_bvalid", 32'(BVALID), 32'd0);
      do_read(4'hC, rd);
      check("after_rst_scratch", rd, 32'h0);
      do_write(4'hC, 32'h0000_0077, 4'hF, st);
      do_read(4'hC, rd);
      check("after_rst_rw", rd, 32'h0000_0077);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
